// File: rtl/data_bus_router_pkg.sv
// Shared types and default memory map for the single-master data bus router.
// Default windows: slave 0 = instruction/data RAM, slave 1 = data RAM, others spread from 0xC000_0000.
package data_bus_router_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} bus_state_e;

  localparam int          MAX_SLAVES  = 16;
  localparam int          ERR_CNT_W   = 8;
  localparam logic [31:0] RAM_I_BASE  = 32'h8000_0000;
  localparam logic [31:0] RAM_D_BASE  = 32'h9000_0000;
  localparam logic [31:0] WIN_MASK    = 32'hFFFF_FF00;

  function automatic logic [MAX_SLAVES*32-1:0] def_bases();
    logic [MAX_SLAVES*32-1:0] b;
    for (int i = 0; i < MAX_SLAVES; i++) b[i*32 +: 32] = 32'hC000_0000 + 32'(i) * 32'h0100_0000;
    b[31:0]  = RAM_I_BASE;
    b[63:32] = RAM_D_BASE;
    return b;
  endfunction

  localparam logic [MAX_SLAVES*32-1:0] DEF_SLAVE_BASE = def_bases();
  localparam logic [MAX_SLAVES*32-1:0] DEF_SLAVE_MASK = {MAX_SLAVES{WIN_MASK}};

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/data_bus_router_addr_decoder.sv
// Combinational window decode: per-window match, lowest index wins on overlap.
module addr_decoder #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W     = 32,
  parameter int IDX_W      = 2,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] BASE = '0,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] MASK = '0
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] onehot,
  output logic [IDX_W-1:0]      idx,
  output logic                  hit
);

  logic [NUM_SLAVES-1:0] raw;

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_win
    assign raw[i] = (addr & MASK[i*ADDR_W +: ADDR_W]) ==
                    (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W]);
  end

  // Walk downward so the lowest matching index is the one left standing.
  always_comb begin
    onehot = '0;
    idx    = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--) begin
      if (raw[i]) begin
        onehot    = '0;
        onehot[i] = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end

  assign hit = |raw;

endmodule

// File: rtl/data_bus_router.sv
// Single-outstanding master-to-N-slave router with address decode, ack timeout
// and sticky error address / saturating error count.
module data_bus_router
  import data_bus_router_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = (NUM_SLAVES*ADDR_W)'(DEF_SLAVE_BASE),
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = (NUM_SLAVES*ADDR_W)'(DEF_SLAVE_MASK),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         m_req,
  input  logic                         m_we,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_ready,
  output logic                         m_rvalid,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic                         s_we,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic [DATA_W/8-1:0]          s_wstrb,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [ERR_CNT_W-1:0]         err_count
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  bus_state_e            state, state_nxt;
  logic [NUM_SLAVES-1:0] dec_onehot, sel_r;
  logic [IDX_W-1:0]      dec_idx, idx_r;
  logic                  dec_hit;
  logic [CNT_W-1:0]      cnt;
  logic                  xfer, ack_sel, tmo;
  logic [DATA_W-1:0]     rdata_r;
  logic                  err_r;

  addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_W     (ADDR_W),
    .IDX_W      (IDX_W),
    .BASE       (SLAVE_BASE),
    .MASK       (SLAVE_MASK)
  ) u_dec (
    .addr   (m_addr),
    .onehot (dec_onehot),
    .idx    (dec_idx),
    .hit    (dec_hit)
  );

  assign m_ready  = (state == ST_IDLE);
  assign xfer     = m_req & m_ready;
  assign ack_sel  = |(s_ack & sel_r);
  assign tmo      = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // Derived from state so an async reset drops the request in the same cycle.
  assign s_req    = (state == ST_WAIT) ? sel_r : '0;
  assign m_rvalid = (state == ST_RESP);
  assign m_rdata  = rdata_r;
  assign m_err    = err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (xfer) state_nxt = dec_hit ? ST_WAIT : ST_RESP;
      ST_WAIT: if (ack_sel || tmo) state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      sel_r     <= '0;
      idx_r     <= '0;
      s_we      <= 1'b0;
      s_addr    <= '0;
      s_wdata   <= '0;
      s_wstrb   <= '0;
      rdata_r   <= '0;
      err_r     <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (xfer) begin
            s_we    <= m_we;
            s_addr  <= m_addr;
            s_wdata <= m_wdata;
            s_wstrb <= m_wstrb;
            sel_r   <= dec_onehot;
            idx_r   <= dec_idx;
            if (!dec_hit) begin
              rdata_r   <= '0;
              err_r     <= 1'b1;
              err_addr  <= m_addr;
              err_count <= sat_inc(err_count);
            end
          end
        end
        ST_WAIT: begin
          // Ack is checked first so it wins over a simultaneous timeout.
          if (ack_sel) begin
            rdata_r <= s_we ? '0 : s_rdata[int'(idx_r)*DATA_W +: DATA_W];
            err_r   <= 1'b0;
          end else if (tmo) begin
            rdata_r   <= '0;
            err_r     <= 1'b1;
            err_addr  <= s_addr;
            err_count <= sat_inc(err_count);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_router.sv
// Directed + randomized bench for data_bus_router with a transaction-level reference model.
module tb_data_bus_router;

  localparam int NS  = 4;
  localparam int TMO = 16;
  localparam logic [31:0] MASK = 32'hFFFF_FF00;
  // Slave 2 deliberately overlaps slave 0 to exercise priority.
  localparam logic [31:0] BASES [NS] = '{32'h8000_0000, 32'h9000_0000, 32'h8000_0000, 32'hC000_0000};
  localparam logic [NS*32-1:0] P_BASE = {32'hC000_0000, 32'h8000_0000, 32'h9000_0000, 32'h8000_0000};

  logic          clk = 1'b0, rst = 1'b1;
  logic          m_req = 1'b0, m_we = 1'b0;
  logic [31:0]   m_addr = '0, m_wdata = '0;
  logic [3:0]    m_wstrb = '0;
  logic          m_ready, m_rvalid, m_err;
  logic [31:0]   m_rdata;
  logic [NS-1:0] s_req;
  logic          s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_wstrb;
  logic [NS-1:0] s_ack = '0;
  logic [NS*32-1:0] s_rdata = '0;
  logic [31:0]   err_addr;
  logic [7:0]    err_count;

  int checks = 0, failures = 0;
  int err_cnt_m = 0;
  logic [31:0] err_addr_m = '0;

  always #5 clk = ~clk;

  data_bus_router #(
    .NUM_SLAVES(NS), .ADDR_W(32), .DATA_W(32),
    .SLAVE_BASE(P_BASE), .SLAVE_MASK({NS{MASK}}), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ack(s_ack), .s_rdata(s_rdata),
    .err_addr(err_addr), .err_count(err_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ack_k: WAIT cycle (1-based) in which the selected slave acks; 0 = never.
  task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                         input logic [3:0] ws, input int ack_k, input logic [31:0] rd,
                         input logic [3:0] noise);
    int sl, lat, req_n;
    logic e;
    logic [31:0] erd;
    logic [3:0] oh;
    sl = -1;
    for (int i = NS-1; i >= 0; i--) if ((addr & MASK) == (BASES[i] & MASK)) sl = i;
    oh = (sl >= 0) ? 4'(1 << sl) : 4'b0;
    if (sl < 0) begin
      e = 1'b1; erd = '0; req_n = 0; lat = 1;
    end else if (ack_k >= 1 && ack_k <= TMO) begin
      e = 1'b0; erd = we ? 32'h0 : rd; req_n = ack_k; lat = ack_k + 1;
    end else begin
      e = 1'b1; erd = '0; req_n = TMO; lat = TMO + 1;
    end
    @(negedge clk);
    chk("ready_idle", 64'(m_ready), 64'(1'b1));
    m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wd; m_wstrb = ws;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c == 1) begin
        m_req = 1'b0; m_we = ~we; m_addr = $urandom; m_wdata = $urandom; m_wstrb = 4'($urandom);
      end
      chk("s_req", 64'(s_req), 64'((c <= req_n) ? oh : 4'b0));
      if (c <= req_n) begin
        chk("s_addr", 64'(s_addr), 64'(addr));
        chk("s_we", 64'(s_we), 64'(we));
        chk("s_wdata", 64'(s_wdata), 64'(wd));
        chk("s_wstrb", 64'(s_wstrb), 64'(ws));
      end
      chk("m_ready_busy", 64'(m_ready), 64'(1'b0));
      chk("m_rvalid", 64'(m_rvalid), 64'(c == lat));
      if (c == lat) begin
        chk("m_rdata", 64'(m_rdata), 64'(erd));
        chk("m_err", 64'(m_err), 64'(e));
      end
      s_ack = noise & ~oh;
      if (sl >= 0 && c == ack_k) s_ack = s_ack | oh;
      s_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (sl >= 0) s_rdata[sl*32 +: 32] = rd;
    end
    if (e) begin
      err_cnt_m  = (err_cnt_m >= 255) ? 255 : err_cnt_m + 1;
      err_addr_m = addr;
    end
    @(negedge clk);
    s_ack = '0;
    chk("ready_after", 64'(m_ready), 64'(1'b1));
    chk("rvalid_after", 64'(m_rvalid), 64'(1'b0));
    chk("err_count", 64'(err_count), 64'(err_cnt_m));
    chk("err_addr", 64'(err_addr), 64'(err_addr_m));
  endtask

  initial begin
    logic [31:0] a;
    int r;
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(m_ready), 64'(1'b1));
    chk("rst_s_req", 64'(s_req), 64'(4'b0));
    chk("rst_rvalid", 64'(m_rvalid), 64'(1'b0));
    chk("rst_err", 64'(m_err), 64'(1'b0));
    chk("rst_rdata", 64'(m_rdata), 64'(32'h0));
    chk("rst_s_bus", 64'({s_we, s_wstrb, s_addr}), 64'(0));
    chk("rst_s_wdata", 64'(s_wdata), 64'(32'h0));
    chk("rst_err_addr", 64'(err_addr), 64'(32'h0));
    chk("rst_err_count", 64'(err_count), 64'(8'h0));
    rst = 1'b0;

    run_txn(32'h8000_0004, 1'b0, 32'h0, 4'h0, 1, 32'hDEAD_BEEF, 4'h0);
    run_txn(32'h9000_0010, 1'b1, 32'h1234_5678, 4'hF, 3, 32'hFFFF_FFFF, 4'h0);
    run_txn(32'hA000_0000, 1'b0, 32'h0, 4'h0, 1, 32'h5555_5555, 4'h0);
    run_txn(32'h8000_0008, 1'b0, 32'h0, 4'h0, 0, 32'h0, 4'h0);
    run_txn(32'h8000_000C, 1'b0, 32'h0, 4'h0, 16, 32'hCAFE_F00D, 4'h0);
    run_txn(32'h8000_0010, 1'b0, 32'h0, 4'h0, 15, 32'h0BAD_CAFE, 4'h0);
    run_txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 0, 32'h0, 4'b0100);
    run_txn(32'h8000_0000, 1'b0, 32'h0, 4'h0, 3, 32'h1357_9BDF, 4'b1110);
    run_txn(32'hC000_00FF, 1'b1, 32'hA5A5_5A5A, 4'h3, 2, 32'h0, 4'b0111);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 4);
      case (r)
        0: a = 32'h8000_0000 | 32'($urandom_range(0, 255));
        1: a = 32'h9000_0000 | 32'($urandom_range(0, 255));
        2: a = 32'hC000_0000 | 32'($urandom_range(0, 255));
        3: a = $urandom;
        default: a = 32'h8000_0100 | 32'($urandom_range(0, 255));
      endcase
      run_txn(a, 1'($urandom), $urandom, 4'($urandom), $urandom_range(0, 18), $urandom, 4'($urandom));
    end

    // Reset while WAIT: request must vanish at once and no response follows.
    @(negedge clk);
    m_req = 1'b1; m_we = 1'b0; m_addr = 32'h8000_0020;
    @(negedge clk);
    m_req = 1'b0;
    chk("wait_s_req", 64'(s_req), 64'(4'b0001));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_s_req", 64'(s_req), 64'(4'b0));
    chk("async_rvalid", 64'(m_rvalid), 64'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    err_cnt_m = 0; err_addr_m = '0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_rvalid", 64'(m_rvalid), 64'(1'b0));
      chk("post_rst_ready", 64'(m_ready), 64'(1'b1));
      chk("post_rst_s_req", 64'(s_req), 64'(4'b0));
    end
    chk("post_rst_err_count", 64'(err_count), 64'(8'h0));

    // Drive the error counter past its saturation point.
    for (int n = 0; n < 258; n++)
      run_txn(32'hA000_0000 + 32'(n), 1'b0, 32'h0, 4'h0, 1, 32'h0, 4'($urandom));
    chk("err_count_sat", 64'(err_count), 64'(8'd255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
